// File: rtl/chi_scan_scheduler.sv
// chi_scan_scheduler: walks NUM_OSCILLATORS omega_dt values through a shared
// chi evaluator, one request at a time. It tracks the chi extrema, the index
// of the maximum and the count of boundary-class results, then publishes them
// at the end of each scan. Evaluations that never answer are cut off after
// TIMEOUT_CYCLES and flagged.
// Optional build macro: CHI_SCAN_CONTINUOUS_EN. When it is defined, each scan
// re-latches its inputs and starts again immediately after DONE.
module chi_scan_scheduler #(
    parameter int WIDTH           = 18,
    parameter int FRAC            = 14,
    parameter int NUM_OSCILLATORS = 21,
    parameter int TIMEOUT_CYCLES  = 15
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             clk_en,
    input  logic                             start,
    input  logic [NUM_OSCILLATORS*WIDTH-1:0] omega_dt_packed,
    input  logic [WIDTH-1:0]                 omega_dt_reference,
    output logic                             eval_req,
    output logic [WIDTH-1:0]                 eval_omega,
    output logic [WIDTH-1:0]                 eval_ref,
    input  logic                             eval_valid,
    input  logic [WIDTH-1:0]                 eval_chi,
    input  logic [1:0]                       eval_class,
    output logic                             busy,
    output logic                             done,
    output logic [WIDTH-1:0]                 chi_max,
    output logic [WIDTH-1:0]                 chi_min,
    output logic [4:0]                       chi_max_index,
    output logic [4:0]                       boundary_count,
    output logic                             timeout_err
);
    // The Q format needs at least a sign bit above the fraction.
    if (FRAC >= WIDTH) begin : g_frac_check
        $error("FRAC must be smaller than WIDTH");
    end

    localparam int WCW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] MOST_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [4:0]       LAST_IDX = 5'(NUM_OSCILLATORS - 1);
    localparam logic [WCW-1:0]   WAIT_LAST = WCW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_UPDATE, S_DONE} state_t;

    state_t                                   state_q;
    logic [NUM_OSCILLATORS-1:0][WIDTH-1:0]    om_q;
    logic [WIDTH-1:0]                         ref_q;
    logic [4:0]                               idx_q;
    logic [WCW-1:0]                           wcnt_q;
    logic                                     res_vld_q;
    logic [WIDTH-1:0]                         res_chi_q;
    logic [1:0]                               res_cls_q;
    logic [WIDTH-1:0]                         acc_max_q, acc_min_q;
    logic [4:0]                               acc_idx_q, acc_cnt_q;
    logic [WIDTH-1:0]                         acc_max_d, acc_min_d;
    logic [4:0]                               acc_idx_d, acc_cnt_d;
    logic                                     eval_req_q, busy_q, done_q, tmo_q;
    logic [WIDTH-1:0]                         pub_max_q, pub_min_q;
    logic [4:0]                               pub_idx_q, pub_cnt_q;
    logic                                     launch;

    assign eval_req       = eval_req_q;
    assign eval_omega     = om_q[idx_q];
    assign eval_ref       = ref_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign timeout_err    = tmo_q;
    assign chi_max        = pub_max_q;
    assign chi_min        = pub_min_q;
    assign chi_max_index  = pub_idx_q;
    assign boundary_count = pub_cnt_q;

    // A scan begins on start from IDLE, or straight out of DONE in continuous mode.
`ifdef CHI_SCAN_CONTINUOUS_EN
    assign launch = (state_q == S_IDLE && start) || (state_q == S_DONE);
`else
    assign launch = (state_q == S_IDLE && start);
`endif

    // Fold the captured result into the accumulators; a timed-out slot leaves them untouched.
    always_comb begin
        acc_max_d = acc_max_q;
        acc_min_d = acc_min_q;
        acc_idx_d = acc_idx_q;
        acc_cnt_d = acc_cnt_q;
        if (res_vld_q) begin
            if ($signed(res_chi_q) > $signed(acc_max_q)) begin
                acc_max_d = res_chi_q;
                acc_idx_d = idx_q;
            end
            if ($signed(res_chi_q) < $signed(acc_min_q))
                acc_min_d = res_chi_q;
            if (res_cls_q == 2'b01)
                acc_cnt_d = acc_cnt_q + 5'd1;
        end
    end

    // Scan FSM with registered request, busy, done and published results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            om_q       <= '0;
            ref_q      <= '0;
            idx_q      <= '0;
            wcnt_q     <= '0;
            res_vld_q  <= 1'b0;
            res_chi_q  <= '0;
            res_cls_q  <= '0;
            acc_max_q  <= '0;
            acc_min_q  <= '0;
            acc_idx_q  <= '0;
            acc_cnt_q  <= '0;
            eval_req_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            tmo_q      <= 1'b0;
            pub_max_q  <= '0;
            pub_min_q  <= '0;
            pub_idx_q  <= '0;
            pub_cnt_q  <= '0;
        end else if (clk_en) begin
            eval_req_q <= 1'b0;
            done_q     <= 1'b0;
            if (launch) begin
                om_q       <= omega_dt_packed;
                ref_q      <= omega_dt_reference;
                idx_q      <= '0;
                acc_max_q  <= MOST_NEG;
                acc_min_q  <= MOST_POS;
                acc_idx_q  <= '0;
                acc_cnt_q  <= '0;
                tmo_q      <= 1'b0;
                busy_q     <= 1'b1;
                eval_req_q <= 1'b1;
                state_q    <= S_ISSUE;
            end else begin
                case (state_q)
                    S_ISSUE: begin
                        wcnt_q    <= '0;
                        res_vld_q <= 1'b0;
                        state_q   <= S_WAIT;
                    end
                    S_WAIT: begin
                        // A result on the final wait cycle still counts as valid.
                        if (eval_valid) begin
                            res_vld_q <= 1'b1;
                            res_chi_q <= eval_chi;
                            res_cls_q <= eval_class;
                            state_q   <= S_UPDATE;
                        end else if (wcnt_q == WAIT_LAST) begin
                            tmo_q   <= 1'b1;
                            state_q <= S_UPDATE;
                        end else begin
                            wcnt_q <= wcnt_q + 1'b1;
                        end
                    end
                    S_UPDATE: begin
                        acc_max_q <= acc_max_d;
                        acc_min_q <= acc_min_d;
                        acc_idx_q <= acc_idx_d;
                        acc_cnt_q <= acc_cnt_d;
                        if (idx_q == LAST_IDX) begin
                            pub_max_q <= acc_max_d;
                            pub_min_q <= acc_min_d;
                            pub_idx_q <= acc_idx_d;
                            pub_cnt_q <= acc_cnt_d;
                            done_q    <= 1'b1;
                            state_q   <= S_DONE;
                        end else begin
                            idx_q      <= idx_q + 5'd1;
                            eval_req_q <= 1'b1;
                            state_q    <= S_ISSUE;
                        end
                    end
                    S_DONE: begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_chi_scan_scheduler.sv
// Directed bench for chi_scan_scheduler. It uses a behavioural evaluator with
// latency 3 and chi = 16384 - 4*|omega - ref|. Results are boundary class when
// omega == ref. An omega of SILENT is never answered.
module tb_chi_scan_scheduler;
    localparam int N   = 21;
    localparam int W   = 18;
    localparam int LAT = 3;
    localparam logic [W-1:0] REF    = 18'd4096;
    localparam logic [W-1:0] SILENT = 18'd1000;

    logic               clk = 1'b0;
    logic               rst, clk_en, start;
    logic [N-1:0][W-1:0] om;
    logic               eval_req, eval_valid, busy, done, timeout_err;
    logic [W-1:0]       eval_omega, eval_ref, eval_chi, chi_max, chi_min;
    logic [1:0]         eval_class;
    logic [4:0]         chi_max_index, boundary_count;
    int                 checks = 0;
    int                 failures = 0;
    int                 mcnt;

    chi_scan_scheduler dut (
        .clk(clk), .rst(rst), .clk_en(clk_en), .start(start),
        .omega_dt_packed(om), .omega_dt_reference(REF),
        .eval_req(eval_req), .eval_omega(eval_omega), .eval_ref(eval_ref),
        .eval_valid(eval_valid), .eval_chi(eval_chi), .eval_class(eval_class),
        .busy(busy), .done(done), .chi_max(chi_max), .chi_min(chi_min),
        .chi_max_index(chi_max_index), .boundary_count(boundary_count),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] model_chi(input logic [W-1:0] o, input logic [W-1:0] r);
        int d;
        d = int'($signed(o)) - int'($signed(r));
        if (d < 0) d = -d;
        return W'(16384 - 4 * d);
    endfunction

    // Evaluator model: answers LAT cycles after eval_req, frozen while clk_en is low.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            eval_valid <= 1'b0;
            eval_chi   <= '0;
            eval_class <= '0;
            mcnt       <= 0;
        end else if (clk_en) begin
            eval_valid <= 1'b0;
            if (eval_req) begin
                if (eval_omega != SILENT) begin
                    eval_chi   <= model_chi(eval_omega, eval_ref);
                    eval_class <= (eval_omega == eval_ref) ? 2'b01 : 2'b00;
                    if (LAT == 1) eval_valid <= 1'b1;
                    else          mcnt <= LAT;
                end
            end else if (mcnt == 2) begin
                eval_valid <= 1'b1;
                mcnt       <= 0;
            end else if (mcnt > 2) begin
                mcnt <= mcnt - 1;
            end
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Pulses start, then counts cycles (1 = first cycle after the sampling edge) until done.
    task automatic run_scan(input string tag, input int exp_n, input int restart_at,
                            input int stall_at);
        int n;
        int dones;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        n = 1;
        while (!done && n < 2000) begin
            start = (n == restart_at);
            if (n == stall_at)      clk_en = 1'b0;
            if (n == stall_at + 20) clk_en = 1'b1;
            @(negedge clk);
            n++;
        end
        start  = 1'b0;
        clk_en = 1'b1;
        chk({tag, "_done_cycle"}, n, exp_n);
        dones = done ? 1 : 0;
        repeat (4) begin
            @(negedge clk);
            if (done) dones++;
        end
        chk({tag, "_done_pulses"}, dones, 1);
        chk({tag, "_busy_after"}, int'(busy), 0);
    endtask

    task automatic chk_res(input string tag, input int mx, input int mn, input int ix,
                           input int bc, input int te);
        chk({tag, "_chi_max"}, int'($signed(chi_max)), mx);
        chk({tag, "_chi_min"}, int'($signed(chi_min)), mn);
        chk({tag, "_max_index"}, int'(chi_max_index), ix);
        chk({tag, "_boundary"}, int'(boundary_count), bc);
        chk({tag, "_timeout"}, int'(timeout_err), te);
    endtask

    initial begin
        rst = 1'b1; clk_en = 1'b1; start = 1'b0;
        for (int i = 0; i < N; i++) om[i] = 18'd6144;
        om[0] = REF;
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_req", int'(eval_req), 0);
        chk_res("rst", 0, 0, 0, 0, 0);
        rst = 1'b0;
        @(negedge clk);

`ifdef CHI_SCAN_CONTINUOUS_EN
        begin
            int n;
            int gap;
            start = 1'b1;
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
            n = 1;
            while (!done && n < 2000) begin @(negedge clk); n++; end
            chk("cont_first_done", n, 106);
            chk("cont_busy_in_done", int'(busy), 1);
            gap = 0;
            @(negedge clk);
            gap = 1;
            while (!done && gap < 2000) begin
                chk("cont_busy", int'(busy), 1);
                @(negedge clk);
                gap++;
            end
            chk("cont_gap", gap, 106);
            chk_res("cont", 16384, 8192, 0, 1, 0);
        end
`else
        // Ratio 1.0 at idx 0, 1.5 elsewhere; start re-pulsed mid-scan is ignored.
        run_scan("basic", 106, 50, -1);
        chk_res("basic", 16384, 8192, 0, 1, 0);

        // Equal chi everywhere; clk_en dropped for 20 cycles during a WAIT.
        for (int i = 0; i < N; i++) om[i] = (i % 2 == 0) ? 18'd6144 : 18'd2048;
        run_scan("equal", 126, -1, 52);
        chk_res("equal", 8192, 8192, 0, 0, 0);

        // Tie at idx 7/12, min at idx 15, evaluator silent at idx 5.
        for (int i = 0; i < N; i++) om[i] = 18'd6144;
        om[7] = REF; om[12] = REF; om[15] = 18'd7096; om[5] = SILENT;
        run_scan("silent5", 118, -1, -1);
        chk_res("silent5", 16384, 4384, 7, 2, 1);

        // Every evaluation times out: clear values are published.
        for (int i = 0; i < N; i++) om[i] = SILENT;
        run_scan("allsilent", 358, -1, -1);
        chk_res("allsilent", -131072, 131071, 0, 0, 1);

        // Reset during idx 10 (its WAIT, cycle 53).
        for (int i = 0; i < N; i++) om[i] = 18'd6144;
        om[0] = REF;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (52) @(negedge clk);
        chk("midrst_busy_before", int'(busy), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_req", int'(eval_req), 0);
        chk_res("midrst", 0, 0, 0, 0, 0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("midrst_stays_idle", int'(busy), 0);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
